// File: rtl/ncl_add_sequencer.sv
// Synchronous sequencer for a dual-rail (NCL) ripple adder.
// Encodes binary operands onto DATA rails, waits for adder completion,
// decodes the result, then returns the adder to NULL before the next request.
// Optional feature macro: NCL_SEQ_RAILCHK_EN (rail-pair validity check at capture).
module ncl_add_sequencer #(
    parameter int unsigned WIDTH   = 8,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic               clk,
    input  logic               init,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic               req_cin,
    output logic               resp_valid,
    input  logic               resp_ready,
    output logic [WIDTH-1:0]   resp_sum,
    output logic               resp_cout,
    output logic               resp_err,
    output logic [2*WIDTH-1:0] ncl_a,
    output logic [2*WIDTH-1:0] ncl_b,
    output logic [1:0]         ncl_cin,
    input  logic [2*WIDTH-1:0] ncl_sum,
    input  logic [1:0]         ncl_cout,
    input  logic               ncl_done,
    output logic               ncl_rfd
);

    localparam int unsigned TW = 16;
    localparam logic [TW-1:0] TimeoutVal = TW'(TIMEOUT);

    // StHold: NULL phase finished but the response has not been consumed yet.
    typedef enum logic [2:0] {
        StIdle,
        StDataWait,
        StNullWait,
        StHold,
        StFault
    } state_e;

    state_e state_q, state_d;

    logic               done_meta_q;
    logic               done_s_q;
    logic [2*WIDTH-1:0] ncl_a_q, ncl_a_d;
    logic [2*WIDTH-1:0] ncl_b_q, ncl_b_d;
    logic [1:0]         ncl_cin_q, ncl_cin_d;
    logic               ncl_rfd_q, ncl_rfd_d;
    logic               resp_valid_q, resp_valid_d;
    logic [WIDTH-1:0]   resp_sum_q, resp_sum_d;
    logic               resp_cout_q, resp_cout_d;
    logic               resp_err_q, resp_err_d;
    logic [TW-1:0]      timer_q, timer_d;

    logic               accept;
    logic               resp_fire;
    logic               timer_hit;
    logic [WIDTH-1:0]   dec_sum;
    logic               dec_cout;
    logic               dec_err;

    assign accept    = req_valid & req_ready;
    assign resp_fire = resp_valid_q & resp_ready;
    assign timer_hit = (timer_q == TimeoutVal);

    // Two-flop synchronizer for the asynchronous adder completion signal.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            done_meta_q <= 1'b0;
            done_s_q    <= 1'b0;
        end else begin
            done_meta_q <= ncl_done;
            done_s_q    <= done_meta_q;
        end
    end

    // FSM state register.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // FSM next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle: begin
                if (accept) begin
                    state_d = StDataWait;
                end
            end
            StDataWait: begin
                if (done_s_q || timer_hit) begin
                    state_d = StNullWait;
                end
            end
            StNullWait: begin
                if (!done_s_q) begin
                    state_d = (resp_valid_q && !resp_fire) ? StHold : StIdle;
                end else if (timer_hit) begin
                    state_d = StFault;
                end
            end
            StHold: begin
                if (resp_fire) begin
                    state_d = StIdle;
                end
            end
            StFault: begin
                state_d = StFault;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // FSM outputs: a request is only taken when idle with no pending response.
    always_comb begin
        req_ready = (state_q == StIdle) && !resp_valid_q;
    end

    // Decode the adder result from rail1; optionally flag malformed pairs.
    always_comb begin
        dec_sum  = '0;
        dec_err  = 1'b0;
        dec_cout = ncl_cout[1];
        for (int unsigned i = 0; i < WIDTH; i++) begin
            dec_sum[i] = ncl_sum[2*i+1];
`ifdef NCL_SEQ_RAILCHK_EN
            if (ncl_sum[2*i+1] == ncl_sum[2*i]) begin
                dec_sum[i] = 1'b0;
                dec_err    = 1'b1;
            end
`endif
        end
`ifdef NCL_SEQ_RAILCHK_EN
        if (ncl_cout[1] == ncl_cout[0]) begin
            dec_cout = 1'b0;
            dec_err  = 1'b1;
        end
`endif
    end

    // Next-state for rails, response registers and the wait timer.
    always_comb begin
        ncl_a_d      = ncl_a_q;
        ncl_b_d      = ncl_b_q;
        ncl_cin_d    = ncl_cin_q;
        ncl_rfd_d    = ncl_rfd_q;
        resp_valid_d = resp_valid_q;
        resp_sum_d   = resp_sum_q;
        resp_cout_d  = resp_cout_q;
        resp_err_d   = resp_err_q;

        if (resp_fire) begin
            resp_valid_d = 1'b0;
        end

        case (state_q)
            StIdle: begin
                if (accept) begin
                    // Binary 1 -> rails 10, binary 0 -> rails 01.
                    for (int unsigned i = 0; i < WIDTH; i++) begin
                        ncl_a_d[2*i+1] = req_a[i];
                        ncl_a_d[2*i]   = ~req_a[i];
                        ncl_b_d[2*i+1] = req_b[i];
                        ncl_b_d[2*i]   = ~req_b[i];
                    end
                    ncl_cin_d = {req_cin, ~req_cin};
                end
            end
            StDataWait: begin
                if (done_s_q) begin
                    resp_valid_d = 1'b1;
                    resp_sum_d   = dec_sum;
                    resp_cout_d  = dec_cout;
                    resp_err_d   = dec_err;
                    ncl_a_d      = '0;
                    ncl_b_d      = '0;
                    ncl_cin_d    = '0;
                    ncl_rfd_d    = 1'b0;
                end else if (timer_hit) begin
                    resp_valid_d = 1'b1;
                    resp_sum_d   = '0;
                    resp_cout_d  = 1'b0;
                    resp_err_d   = 1'b1;
                    ncl_a_d      = '0;
                    ncl_b_d      = '0;
                    ncl_cin_d    = '0;
                    ncl_rfd_d    = 1'b0;
                end
            end
            StNullWait: begin
                if (!done_s_q) begin
                    ncl_rfd_d = 1'b1;
                end
            end
            default: begin
            end
        endcase

        // Timer runs only in the wait states and restarts on every transition.
        if (state_d != state_q) begin
            timer_d = '0;
        end else if (state_q == StDataWait || state_q == StNullWait) begin
            timer_d = timer_q + TW'(1);
        end else begin
            timer_d = '0;
        end
    end

    // Datapath and response registers.
    always_ff @(posedge clk or posedge init) begin
        if (init) begin
            ncl_a_q      <= '0;
            ncl_b_q      <= '0;
            ncl_cin_q    <= '0;
            ncl_rfd_q    <= 1'b1;
            resp_valid_q <= 1'b0;
            resp_sum_q   <= '0;
            resp_cout_q  <= 1'b0;
            resp_err_q   <= 1'b0;
            timer_q      <= '0;
        end else begin
            ncl_a_q      <= ncl_a_d;
            ncl_b_q      <= ncl_b_d;
            ncl_cin_q    <= ncl_cin_d;
            ncl_rfd_q    <= ncl_rfd_d;
            resp_valid_q <= resp_valid_d;
            resp_sum_q   <= resp_sum_d;
            resp_cout_q  <= resp_cout_d;
            resp_err_q   <= resp_err_d;
            timer_q      <= timer_d;
        end
    end

    assign ncl_a      = ncl_a_q;
    assign ncl_b      = ncl_b_q;
    assign ncl_cin    = ncl_cin_q;
    assign ncl_rfd    = ncl_rfd_q;
    assign resp_valid = resp_valid_q;
    assign resp_sum   = resp_sum_q;
    assign resp_cout  = resp_cout_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_ncl_add_sequencer.sv
// Self-checking bench for ncl_add_sequencer with a zero-delay dual-rail adder model.
module tb_ncl_add_sequencer;

    localparam int unsigned WIDTH   = 8;
    localparam int unsigned TIMEOUT = 16;

    logic               clk;
    logic               init;
    logic               req_valid;
    logic               req_ready;
    logic [WIDTH-1:0]   req_a;
    logic [WIDTH-1:0]   req_b;
    logic               req_cin;
    logic               resp_valid;
    logic               resp_ready;
    logic [WIDTH-1:0]   resp_sum;
    logic               resp_cout;
    logic               resp_err;
    logic [2*WIDTH-1:0] ncl_a;
    logic [2*WIDTH-1:0] ncl_b;
    logic [1:0]         ncl_cin;
    logic [2*WIDTH-1:0] ncl_sum;
    logic [1:0]         ncl_cout;
    logic               ncl_done;
    logic               ncl_rfd;

    int n_tests = 0;
    int n_fail  = 0;
    // Adder model mode: 0 normal, 1 never completes, 2 completion stuck high, 3 bit-3 pair forced 11.
    int mode    = 0;

    logic [WIDTH:0] exp_q[$];
    int             acc_q[$];

    ncl_add_sequencer #(
        .WIDTH   (WIDTH),
        .TIMEOUT (TIMEOUT)
    ) dut (
        .clk        (clk),
        .init       (init),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .req_cin    (req_cin),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_sum   (resp_sum),
        .resp_cout  (resp_cout),
        .resp_err   (resp_err),
        .ncl_a      (ncl_a),
        .ncl_b      (ncl_b),
        .ncl_cin    (ncl_cin),
        .ncl_sum    (ncl_sum),
        .ncl_cout   (ncl_cout),
        .ncl_done   (ncl_done),
        .ncl_rfd    (ncl_rfd)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [2*WIDTH-1:0] dual_rail(input logic [WIDTH-1:0] v);
        logic [2*WIDTH-1:0] r;
        for (int i = 0; i < WIDTH; i++) begin
            r[2*i+1] = v[i];
            r[2*i]   = ~v[i];
        end
        return r;
    endfunction

    // Zero-delay adder: arithmetic sum when every input pair is DATA, otherwise NULL.
    logic [WIDTH-1:0] m_a, m_b;
    logic             m_all_data;
    logic [WIDTH:0]   m_res;
    always_comb begin
        m_all_data = (ncl_cin[1] != ncl_cin[0]);
        for (int i = 0; i < WIDTH; i++) begin
            m_a[i] = ncl_a[2*i+1];
            m_b[i] = ncl_b[2*i+1];
            if (ncl_a[2*i+1] == ncl_a[2*i] || ncl_b[2*i+1] == ncl_b[2*i]) begin
                m_all_data = 1'b0;
            end
        end
        m_res    = {1'b0, m_a} + {1'b0, m_b} + {{WIDTH{1'b0}}, ncl_cin[1]};
        ncl_sum  = '0;
        ncl_cout = '0;
        ncl_done = 1'b0;
        if (mode != 1 && m_all_data) begin
            ncl_sum  = dual_rail(m_res[WIDTH-1:0]);
            ncl_cout = {m_res[WIDTH], ~m_res[WIDTH]};
            ncl_done = 1'b1;
            if (mode == 3) begin
                ncl_sum[7:6] = 2'b11;
            end
        end
        if (mode == 2) begin
            ncl_done = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp)
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request and step through its accept edge.
    task automatic send(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b, input logic c);
        int n;
        req_a     = a;
        req_b     = b;
        req_cin   = c;
        req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 60) begin
            tick();
            n++;
        end
        chk("req_ready_before_accept", req_ready, 1);
        tick();
        req_valid = 1'b0;
    endtask

    // Cycles from the accept edge until resp_valid is seen (bounded).
    task automatic wait_resp(output int lat);
        lat = 0;
        while (!resp_valid && lat < 100) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (!req_ready && n < 100) begin
            tick();
            n++;
        end
        chk("idle_reached", req_ready, 1);
    endtask

    // Continuous request stream checked against an arithmetic scoreboard.
    task automatic run_stream(input int cycles, input bit bp, input bit first_fixed);
        int               last_acc;
        int               n_acc;
        bit               prev_valid;
        bit               hold;
        bit               acc;
        logic [WIDTH-1:0] h_sum;
        logic             h_cout;
        logic             h_err;
        logic [WIDTH:0]   e;
        exp_q.delete();
        acc_q.delete();
        last_acc   = -1;
        n_acc      = 0;
        prev_valid = 1'b0;
        hold       = 1'b0;
        h_sum      = '0;
        h_cout     = 1'b0;
        h_err      = 1'b0;
        if (first_fixed) begin
            req_a   = 8'hFF;
            req_b   = 8'h01;
            req_cin = 1'b0;
        end else begin
            req_a   = WIDTH'($urandom);
            req_b   = WIDTH'($urandom);
            req_cin = 1'($urandom_range(0, 1));
        end
        for (int cyc = 0; cyc < cycles; cyc++) begin
            req_valid = (cyc < cycles - 14);
            if (bp && cyc < cycles - 14) begin
                resp_ready = ($urandom_range(0, 1) == 1);
            end else begin
                resp_ready = 1'b1;
            end
            if (hold) begin
                chk("stable_valid", resp_valid, 1);
                chk("stable_sum", resp_sum, h_sum);
                chk("stable_cout", resp_cout, h_cout);
                chk("stable_err", resp_err, h_err);
            end
            if (resp_valid && !prev_valid && acc_q.size() > 0) begin
                chk("stream_latency", cyc - acc_q[0] - 1, 3);
            end
            acc = req_valid && req_ready;
            if (acc) begin
                exp_q.push_back({1'b0, req_a} + {1'b0, req_b} + {{WIDTH{1'b0}}, req_cin});
                acc_q.push_back(cyc);
                if (last_acc >= 0) begin
                    if (bp) begin
                        chk("accept_spacing_min", (cyc - last_acc) >= 7, 1);
                    end else begin
                        chk("accept_spacing", cyc - last_acc, 7);
                    end
                end
                last_acc = cyc;
                n_acc++;
            end
            if (resp_valid && resp_ready) begin
                if (exp_q.size() == 0) begin
                    chk("resp_unexpected", resp_valid, 0);
                end else begin
                    e = exp_q.pop_front();
                    void'(acc_q.pop_front());
                    chk("stream_sum", resp_sum, e[WIDTH-1:0]);
                    chk("stream_cout", resp_cout, e[WIDTH]);
                    chk("stream_err", resp_err, 0);
                end
            end
            hold       = resp_valid && !resp_ready;
            h_sum      = resp_sum;
            h_cout     = resp_cout;
            h_err      = resp_err;
            prev_valid = resp_valid;
            tick();
            if (acc) begin
                req_a   = WIDTH'($urandom);
                req_b   = WIDTH'($urandom);
                req_cin = 1'($urandom_range(0, 1));
            end
        end
        chk("stream_drained", exp_q.size(), 0);
        chk("stream_accepts", n_acc >= 5, 1);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat;
        init       = 1'b1;
        req_valid  = 1'b0;
        req_a      = '0;
        req_b      = '0;
        req_cin    = 1'b0;
        resp_ready = 1'b0;
        mode       = 0;

        // Reset state while init is held.
        #12;
        chk("rst_req_ready", req_ready, 1);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_ncl_a", ncl_a, 0);
        chk("rst_ncl_b", ncl_b, 0);
        chk("rst_ncl_cin", ncl_cin, 0);
        chk("rst_ncl_rfd", ncl_rfd, 1);
        chk("rst_resp_err", resp_err, 0);
        chk("rst_resp_sum", resp_sum, 0);
        chk("rst_resp_cout", resp_cout, 0);
        @(posedge clk);
        #1;
        init = 1'b0;
        tick();

        // 0x5A + 0x3C + 1 = 0x97, no carry; response held under backpressure.
        send(8'h5A, 8'h3C, 1'b1);
        chk("enc_ncl_a", ncl_a, dual_rail(8'h5A));
        chk("enc_ncl_b", ncl_b, dual_rail(8'h3C));
        chk("enc_ncl_cin", ncl_cin, 2'b10);
        chk("enc_rfd", ncl_rfd, 1);
        wait_resp(lat);
        chk("basic_latency", lat, 3);
        chk("basic_sum", resp_sum, 8'h97);
        chk("basic_cout", resp_cout, 0);
        chk("basic_err", resp_err, 0);
        chk("basic_null_a", ncl_a, 0);
        chk("basic_null_cin", ncl_cin, 0);
        chk("basic_rfd_low", ncl_rfd, 0);
        chk("basic_busy", req_ready, 0);
        tick();
        tick();
        tick();
        chk("hold_valid", resp_valid, 1);
        chk("hold_sum", resp_sum, 8'h97);
        chk("hold_rfd_back", ncl_rfd, 1);
        chk("hold_not_ready", req_ready, 0);
        resp_ready = 1'b1;
        tick();
        chk("hs_valid_clear", resp_valid, 0);
        chk("hs_ready", req_ready, 1);
        resp_ready = 1'b0;

        // Back-to-back with resp_ready high, first op 0xFF + 0x01.
        run_stream(60, 1'b0, 1'b1);
        // Random operands under random backpressure.
        run_stream(120, 1'b1, 1'b0);
        wait_idle();

        // Adder never completes: DATA timeout after TIMEOUT counted cycles.
        mode       = 1;
        resp_ready = 1'b0;
        send(8'h12, 8'h34, 1'b0);
        wait_resp(lat);
        chk("to_latency", lat, TIMEOUT + 1);
        chk("to_err", resp_err, 1);
        chk("to_sum", resp_sum, 0);
        chk("to_cout", resp_cout, 0);
        chk("to_null_a", ncl_a, 0);
        chk("to_null_b", ncl_b, 0);
        chk("to_rfd_low", ncl_rfd, 0);
        tick();
        chk("to_rfd_back", ncl_rfd, 1);
        resp_ready = 1'b1;
        tick();
        chk("to_valid_clear", resp_valid, 0);
        chk("to_ready", req_ready, 1);
        mode = 0;

        // init in the middle of DATA_WAIT aborts with no response.
        send(8'hAA, 8'h55, 1'b1);
        tick();
        #2;
        init = 1'b1;
        #1;
        chk("abort_a", ncl_a, 0);
        chk("abort_b", ncl_b, 0);
        chk("abort_cin", ncl_cin, 0);
        chk("abort_rfd", ncl_rfd, 1);
        chk("abort_valid", resp_valid, 0);
        @(posedge clk);
        #1;
        req_a     = 8'h13;
        req_b     = 8'h24;
        req_cin   = 1'b1;
        req_valid = 1'b1;
        init      = 1'b0;
        chk("abort_no_resp", resp_valid, 0);
        tick();
        req_valid = 1'b0;
        chk("first_accept_after_init", ncl_a, dual_rail(8'h13));
        wait_resp(lat);
        chk("post_abort_latency", lat, 3);
        chk("post_abort_sum", resp_sum, 8'h38);
        chk("post_abort_cout", resp_cout, 0);
        wait_idle();

        // Completion stuck high: NULL never arrives, sequencer faults.
        mode = 2;
        send(8'h01, 8'h02, 1'b0);
        wait_resp(lat);
        chk("stuck_sum", resp_sum, 8'h03);
        for (int i = 0; i < 40; i++) begin
            tick();
        end
        chk("fault_ready", req_ready, 0);
        chk("fault_rfd", ncl_rfd, 0);
        chk("fault_rails", ncl_a, 0);
        chk("fault_valid_clear", resp_valid, 0);
        init = 1'b1;
        #2;
        mode = 0;
        chk("fault_init_ready", req_ready, 1);
        chk("fault_init_rfd", ncl_rfd, 1);
        tick();
        init = 1'b0;
        tick();
        chk("fault_recovered", req_ready, 1);

        // Malformed sum pair on bit 3.
        mode       = 3;
        resp_ready = 1'b0;
        send(8'h00, 8'h00, 1'b0);
        wait_resp(lat);
`ifdef NCL_SEQ_RAILCHK_EN
        chk("railchk_err", resp_err, 1);
        chk("railchk_sum", resp_sum, 8'h00);
`else
        chk("rail1_err", resp_err, 0);
        chk("rail1_sum", resp_sum, 8'h08);
`endif
        resp_ready = 1'b1;
        tick();
        mode = 0;
        wait_idle();

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/ncl_add_sequencer.md
NCL_ADD_SEQUENCER -- requirements
Module: ncl_add_sequencer

Interface
REQ-001 SHALL have parameter WIDTH, default 8: operand width in bits; the dual-rail adder is WIDTH cells.
REQ-002 SHALL have parameter TIMEOUT, default 255: maximum cycles in any wait state; range 4..65535.
REQ-003 SHALL have port clk, input, 1 bit: sole clock, rising edge. One clock; reset is asynchronous and active-high.
REQ-004 SHALL have port init, input, 1 bit: asynchronous active-high reset.
REQ-005 SHALL have port req_valid, input, 1 bit: operand request valid.
REQ-006 SHALL have port req_ready, output, 1 bit: sequencer accepts a request.
REQ-007 SHALL have port req_a, input, WIDTH bits: operand A, binary.
REQ-008 SHALL have port req_b, input, WIDTH bits: operand B, binary.
REQ-009 SHALL have port req_cin, input, 1 bit: carry-in, binary.
REQ-010 SHALL have port resp_valid, output, 1 bit: result valid.
REQ-011 SHALL have port resp_ready, input, 1 bit: result consumed.
REQ-012 SHALL have port resp_sum, output, WIDTH bits: decoded sum.
REQ-013 SHALL have port resp_cout, output, 1 bit: decoded carry-out.
REQ-014 SHALL have port resp_err, output, 1 bit: result invalid (timeout or rail error).
REQ-015 SHALL have ports ncl_a and ncl_b, outputs, 2*WIDTH bits each: dual-rail operands; bit i is the pair {[2i+1]=rail1, [2i]=rail0}.
REQ-016 SHALL have port ncl_cin, output, 2 bits: dual-rail carry-in.
REQ-017 SHALL have port ncl_sum, input, 2*WIDTH bits: dual-rail sum from the adder.
REQ-018 SHALL have port ncl_cout, input, 2 bits: dual-rail carry-out.
REQ-019 SHALL have port ncl_done, input, 1 bit: adder output completion; 1 = all DATA, 0 = all NULL.
REQ-020 SHALL have port ncl_rfd, output, 1 bit: driven to the adder output-completion inputs; 1 = request-for-data, 0 = request-for-null.

Function
REQ-021 SHALL implement states IDLE, DATA_WAIT, NULL_WAIT, HOLD, FAULT.
REQ-022 SHALL assert req_ready only in IDLE with resp_valid=0.
REQ-023 On accept (req_valid & req_ready at edge): register dual-rail encodings of req_a/req_b/req_cin onto ncl_a/ncl_b/ncl_cin (1 -> 10, 0 -> 01); clear the timer; enter DATA_WAIT.
REQ-024 SHALL pass ncl_done through a 2-flop synchronizer (done_s); no other use of raw ncl_done.
REQ-025 In DATA_WAIT with done_s=1: capture ncl_sum/ncl_cout decoded from rail1; set resp_valid=1; drive all rails 00; set ncl_rfd=0; enter NULL_WAIT.
REQ-026 In NULL_WAIT with done_s=0: set ncl_rfd=1; enter IDLE.
REQ-027 Latency with zero-delay adder: resp_valid rises 3 cycles after the accept edge; the next accept occurs no earlier than 7 cycles after the accept edge.
REQ-028 resp_valid, resp_sum, resp_cout and resp_err SHALL hold stable until resp_valid & resp_ready at an edge, then resp_valid clears.
REQ-029 If resp_ready is already high when resp_valid rises, the response SHALL complete in that cycle; this SHALL not shorten the NULL phase.
REQ-030 Timer counts cycles in DATA_WAIT and NULL_WAIT; it clears on every state change.
REQ-031 DATA_WAIT timeout (timer = TIMEOUT): set resp_valid=1, resp_err=1, resp_sum=0, resp_cout=0; drive NULL with ncl_rfd=0; enter NULL_WAIT.
REQ-032 NULL_WAIT timeout: enter FAULT; rails stay 00; ncl_rfd stays 0; req_ready stays 0 until init.
REQ-033 Request inputs SHALL be ignored outside IDLE.
REQ-034 Operands SHALL never change while in DATA_WAIT.

Reset
REQ-035 init=1 SHALL asynchronously force state=IDLE, all ncl rails 00, ncl_rfd=1, resp_valid=0, resp_err=0, resp_sum=0, resp_cout=0, timer=0, synchronizer=0.
REQ-036 init during DATA_WAIT or NULL_WAIT SHALL abort the operation with no response; the first accept is allowed on the first edge after deassertion.

Configuration
REQ-037 Macro NCL_SEQ_RAILCHK_EN defined: at DATA capture, any sum/cout pair equal to 00 or 11 SHALL set resp_err=1 and force that decoded bit to 0.
REQ-038 Macro NCL_SEQ_RAILCHK_EN undefined: no rail check; decoding uses rail1 only; resp_err is set only by timeout.

Verification
REQ-039 WIDTH=8, A=0x5A, B=0x3C, cin=1 with a zero-delay adder model -> resp_sum=0x97, resp_cout=0, resp_err=0, resp_valid 3 cycles after accept.
REQ-040 A=0xFF, B=0x01, cin=0 -> resp_sum=0x00, resp_cout=1; back-to-back requests accepted exactly 7 cycles apart with resp_ready tied high.
REQ-041 Model never asserts ncl_done, TIMEOUT=16 -> resp_err=1 and resp_sum=0 after 16 DATA_WAIT cycles; rails go 00.
REQ-042 Model holds ncl_done=1 -> NULL timeout, then FAULT with req_ready=0; init pulse -> IDLE with req_ready=1.
REQ-043 init asserted mid-DATA_WAIT -> all rails 00, ncl_rfd=1, and no resp_valid.
REQ-044 With NCL_SEQ_RAILCHK_EN defined, inject sum bit 3 pair = 11 -> resp_err=1 and resp_sum[3]=0.
